fp_divider_param: RTL and testbench



---
 rtl/fp_divider_param.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_divider_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_divider_param.sv
// Parametrised IEEE-754 divider: radix-2 restoring divide with round-to-nearest-even,
// canonical quiet NaN and exception flags, behind an stb/ack operand/result handshake.
module fp_divider_param #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXP_W+MANT_W:0]   input_a,
  input  logic                    input_a_stb,
  output logic                    input_a_ack,
  input  logic [EXP_W+MANT_W:0]   input_b,
  input  logic                    input_b_stb,
  output logic                    input_b_ack,
  output logic [EXP_W+MANT_W:0]   output_z,
  output logic [4:0]              output_z_flags,
  output logic                    output_z_stb,
  input  logic                    output_z_ack
);

  localparam int unsigned W     = 1 + EXP_W + MANT_W;
  localparam int unsigned EW    = EXP_W + 3;
  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned CNT_W = $clog2(MANT_W + 4);
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX   = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN   = $signed(EW'(1)) - BIAS_E;
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(MANT_W + 2);
  localparam logic [CNT_W-1:0] DEN_CAP  = CNT_W'(MANT_W + 3);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM, DIVIDE, NORM_Q, DENORM, ROUND, PACK, PUT_Z
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]           a_r, b_r;
  logic                   z_sgn;
  logic signed [EW-1:0]   a_e, b_e, z_e;
  logic [MANT_W:0]        a_m, b_m, z_m;
  logic [MANT_W+2:0]      quot;
  logic [MANT_W+1:0]      rem;
  logic                   guard, sticky, tiny, inexact;
  logic [CNT_W-1:0]       cnt;
  logic                   a_ack_nxt, b_ack_nxt, z_stb_nxt;

  // Operand field decode straight from the latched words
  logic                   a_sgn, b_sgn;
  logic [EXP_W-1:0]       a_fld, b_fld;
  logic [MANT_W-1:0]      a_frac, b_frac;
  logic                   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign a_sgn  = a_r[W-1];
  assign b_sgn  = b_r[W-1];
  assign a_fld  = a_r[W-2:MANT_W];
  assign b_fld  = b_r[W-2:MANT_W];
  assign a_frac = a_r[MANT_W-1:0];
  assign b_frac = b_r[MANT_W-1:0];
  assign a_nan  = (&a_fld) && (a_frac != '0);
  assign b_nan  = (&b_fld) && (b_frac != '0);
  assign a_snan = a_nan && !a_frac[MANT_W-1];
  assign b_snan = b_nan && !b_frac[MANT_W-1];
  assign a_inf  = (&a_fld) && (a_frac == '0);
  assign b_inf  = (&b_fld) && (b_frac == '0);
  assign a_zero = (a_fld == '0) && (a_frac == '0);
  assign b_zero = (b_fld == '0) && (b_frac == '0);

  logic           special_hit;
  logic [W-1:0]   spec_z;
  logic [4:0]     spec_flags;
  assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Special-operand result, first matching rule wins
  always_comb begin
    spec_z     = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_z        = QNAN;
      spec_flags[4] = a_snan | b_snan;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_z        = QNAN;
      spec_flags[4] = 1'b1;
    end else if (a_inf) begin
      spec_z = {z_sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_z = {z_sgn, {(W-1){1'b0}}};
    end else if (b_zero) begin
      spec_z        = {z_sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      spec_flags[3] = 1'b1;
    end
  end

  logic [MANT_W+1:0] b_ext, rem_sub, rem_nxt;
  logic              q_bit;
  logic [MANT_W+2:0] qn;
  logic              rnd_up, ovf, den_go;
  logic [MANT_W+1:0] rnd_sum;
  logic [EXP_W-1:0]  pack_fld;

  assign b_ext    = {1'b0, b_m};
  assign q_bit    = rem >= b_ext;
  assign rem_sub  = q_bit ? rem - b_ext : rem;
  assign rem_nxt  = rem_sub << 1;
  assign qn       = quot[MANT_W+2] ? quot : quot << 1;
  assign den_go   = (z_e < EMIN) && (cnt != DEN_CAP);
  assign rnd_up   = guard & (sticky | z_m[0]);
  assign rnd_sum  = {1'b0, z_m} + (MANT_W+2)'(rnd_up);
  assign ovf      = z_e > EMAX;
  assign pack_fld = z_m[MANT_W] ? EXP_W'(z_e + BIAS_E) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_nxt = GET_B;
      GET_B:   if (input_b_ack && input_b_stb) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = special_hit ? PUT_Z : NORM;
      NORM:    if (a_m[MANT_W] && b_m[MANT_W]) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == DIV_LAST) state_nxt = NORM_Q;
      NORM_Q:  state_nxt = DENORM;
      DENORM:  if (!den_go) state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = PUT_Z;
      PUT_Z:   if (output_z_stb && output_z_ack) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  // Handshake strobes drop on their transfer edge and are held otherwise
  always_comb begin
    a_ack_nxt = (state == GET_A) && !(input_a_ack && input_a_stb);
    b_ack_nxt = (state == GET_B) && !(input_b_ack && input_b_stb);
    z_stb_nxt = (state == PUT_Z) && !(output_z_stb && output_z_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_a_ack    <= 1'b0;
      input_b_ack    <= 1'b0;
      output_z_stb   <= 1'b0;
      output_z       <= '0;
      output_z_flags <= '0;
      a_r <= '0;  b_r <= '0;  z_sgn <= 1'b0;
      a_e <= '0;  b_e <= '0;  z_e <= '0;
      a_m <= '0;  b_m <= '0;  z_m <= '0;
      quot <= '0; rem <= '0;  cnt <= '0;
      guard <= 1'b0; sticky <= 1'b0; tiny <= 1'b0; inexact <= 1'b0;
    end else begin
      input_a_ack  <= a_ack_nxt;
      input_b_ack  <= b_ack_nxt;
      output_z_stb <= z_stb_nxt;
      case (state)
        GET_A: if (input_a_ack && input_a_stb) a_r <= input_a;
        GET_B: if (input_b_ack && input_b_stb) b_r <= input_b;
        UNPACK: begin
          z_sgn <= a_sgn ^ b_sgn;
          a_e   <= (a_fld == '0) ? EMIN : $signed(EW'(a_fld)) - BIAS_E;
          b_e   <= (b_fld == '0) ? EMIN : $signed(EW'(b_fld)) - BIAS_E;
          a_m   <= {a_fld != '0, a_frac};
          b_m   <= {b_fld != '0, b_frac};
        end
        SPECIAL: if (special_hit) begin
          output_z       <= spec_z;
          output_z_flags <= spec_flags;
        end
        NORM: begin
          if (a_m[MANT_W] && b_m[MANT_W]) begin
            rem  <= {1'b0, a_m};
            quot <= '0;
            cnt  <= '0;
            z_e  <= a_e - b_e;
          end else begin
            if (!a_m[MANT_W]) begin a_m <= a_m << 1; a_e <= a_e - ONE_E; end
            if (!b_m[MANT_W]) begin b_m <= b_m << 1; b_e <= b_e - ONE_E; end
          end
        end
        DIVIDE: begin
          quot <= {quot[MANT_W+1:0], q_bit};
          rem  <= rem_nxt;
          cnt  <= cnt + CNT_W'(1);
        end
        NORM_Q: begin
          z_m    <= qn[MANT_W+2:2];
          guard  <= qn[1];
          sticky <= qn[0] | (rem != '0);
          cnt    <= '0;
          if (!quot[MANT_W+2]) z_e <= z_e - ONE_E;
        end
        DENORM: if (den_go) begin
          z_m    <= z_m >> 1;
          guard  <= z_m[0];
          sticky <= sticky | guard;
          z_e    <= z_e + ONE_E;
          cnt    <= cnt + CNT_W'(1);
        end
        ROUND: begin
          tiny    <= !z_m[MANT_W];
          inexact <= guard | sticky;
          if (rnd_sum[MANT_W+1]) begin
            z_m <= rnd_sum[MANT_W+1:1];
            z_e <= z_e + ONE_E;
          end else begin
            z_m <= rnd_sum[MANT_W:0];
          end
        end
        PACK: begin
          if (ovf) begin
            output_z       <= {z_sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            output_z_flags <= 5'b00101;
          end else begin
            output_z       <= {z_sgn, pack_fld, z_m[MANT_W-1:0]};
            output_z_flags <= {3'b000, tiny & inexact, inexact};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_param.sv
// Scoreboard bench for fp_divider_param at single (8/23) and half (5/10) precision.
module tb_fp_divider_param;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  f;
  } exp_t;

  logic clk, rst;
  logic [31:0] a32, b32, z32;
  logic        a_stb32, b_stb32, a_ack32, b_ack32, z_stb32, z_ack32;
  logic [4:0]  f32;
  logic [15:0] a16, b16, z16;
  logic        a_stb16, b_stb16, a_ack16, b_ack16, z_stb16, z_ack16;
  logic [4:0]  f16;

  exp_t sb32[$];
  exp_t sb16[$];
  int passed = 0;
  int total  = 0;
  int n32 = 0;
  int n16 = 0;

  fp_divider_param dut32 (
    .clk(clk), .rst(rst),
    .input_a(a32), .input_a_stb(a_stb32), .input_a_ack(a_ack32),
    .input_b(b32), .input_b_stb(b_stb32), .input_b_ack(b_ack32),
    .output_z(z32), .output_z_flags(f32), .output_z_stb(z_stb32), .output_z_ack(z_ack32)
  );

  fp_divider_param #(.EXP_W(5), .MANT_W(10)) dut16 (
    .clk(clk), .rst(rst),
    .input_a(a16), .input_a_stb(a_stb16), .input_a_ack(a_ack16),
    .input_b(b16), .input_b_stb(b_stb16), .input_b_ack(b_ack16),
    .output_z(z16), .output_z_flags(f16), .output_z_stb(z_stb16), .output_z_ack(z_ack16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    total++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitors: compare on every result transfer
  always @(negedge clk) begin
    if (!rst && z_stb32 && z_ack32) begin
      exp_t e;
      n32++;
      if (sb32.size() == 0) tmo($sformatf("unexpected_result32_%0d", n32));
      else begin
        e = sb32.pop_front();
        check($sformatf("z32_%0d", n32), z32, e.z);
        check($sformatf("flags32_%0d", n32), f32, e.f);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && z_stb16 && z_ack16) begin
      exp_t e;
      n16++;
      if (sb16.size() == 0) tmo($sformatf("unexpected_result16_%0d", n16));
      else begin
        e = sb16.pop_front();
        check($sformatf("z16_%0d", n16), 32'(z16), e.z);
        check($sformatf("flags16_%0d", n16), f16, e.f);
      end
    end
  end

  // Hand a, then b (after bstall idle cycles) to one DUT; returns 1 ns after the b edge
  task automatic issue(input bit h, input logic [31:0] a, input logic [31:0] b, input int bstall);
    int n;
    if (h) begin a16 = a[15:0]; a_stb16 = 1'b1; end
    else   begin a32 = a;       a_stb32 = 1'b1; end
    n = 0;
    while (!(h ? a_ack16 : a_ack32) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) tmo("a_ack_wait");
    @(posedge clk); #1;
    a_stb16 = 1'b0; a_stb32 = 1'b0;
    repeat (bstall) @(posedge clk);
    #1;
    if (h) begin b16 = b[15:0]; b_stb16 = 1'b1; end
    else   begin b32 = b;       b_stb32 = 1'b1; end
    n = 0;
    while (!(h ? b_ack16 : b_ack32) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) tmo("b_ack_wait");
    @(posedge clk); #1;
    b_stb16 = 1'b0; b_stb32 = 1'b0;
  endtask

  task automatic run(input bit h, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ez, input logic [4:0] ef,
                     input int bstall, input int lat);
    int k;
    exp_t e;
    e.z = ez;
    e.f = ef;
    if (h) sb16.push_back(e); else sb32.push_back(e);
    issue(h, a, b, bstall);
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!(h ? z_stb16 : z_stb32) && k < 400);
    if (!(h ? z_stb16 : z_stb32)) tmo("z_stb_wait");
    else if (lat >= 0) check($sformatf("latency_%0h_%0h", a, b), k, lat);
  endtask

  initial begin
    rst = 1'b1;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    a_stb32 = 1'b0; b_stb32 = 1'b0; z_ack32 = 1'b1;
    a_stb16 = 1'b0; b_stb16 = 1'b0; z_ack16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs32", {a_ack32, b_ack32, z_stb32, f32, z32}, 64'h0);
    check("reset_outputs16", {a_ack16, b_ack16, z_stb16, f16, z16}, 64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("a_ack_after_reset", {a_ack32, a_ack16}, 2'b11);

    run(0, 32'h3F800000, 32'h40000000, 32'h3F000000, 5'b00000, 0, 34);
    run(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 7, -1);
    run(0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 0, 3);
    run(0, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 0, 3);
    run(0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 0, 3);
    run(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 0, 3);
    run(0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 0, 34);
    run(0, 32'h00000001, 32'h40000000, 32'h00000000, 5'b00011, 0, 81);
    run(0, 32'h00800000, 32'h40000000, 32'h00400000, 5'b00000, 0, 35);
    run(1, 32'h3C00, 32'h4200, 32'h3555, 5'b00001, 0, 21);
    run(1, 32'h7BFF, 32'h3800, 32'h7C00, 5'b00101, 0, 21);

    // Consumer stalls for 20 cycles: result must be held
    z_ack32 = 1'b0;
    run(0, 32'h3F800000, 32'h40000000, 32'h3F000000, 5'b00000, 0, 34);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), {z_stb32, z32}, {1'b1, 32'h3F000000});
    end
    z_ack32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset ten cycles into the divide loop
    issue(0, 32'h3F800000, 32'h40400000, 0);
    repeat (13) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_mid_divide", {a_ack32, b_ack32, z_stb32, f32, z32}, 64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("a_ack_after_mid_reset", a_ack32, 1'b1);
    run(0, 32'h40800000, 32'h40000000, 32'h40000000, 5'b00000, 0, 34);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", {32'(sb32.size()), 32'(sb16.size())}, 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
